pixel_layer_mixer: RTL and testbench

//  Parametrised N-layer VGA pixel compositor. Sits between the sprite/tile generators
//  (bomberman, walls, enemies, bombs, explosions) and the vgaR/G/B pins. Picks the

---
 rtl/video_pkg.sv | 26 ++
 rtl/priority_encoder_n.sv | 25 ++
 rtl/pixel_layer_mixer.sv | 131 +++++++++++++
 tb/tb_pixel_layer_mixer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants for the pixel compositor: default colour format,
// colour key and the fixed layer ordering used by the game.
package video_pkg;

    localparam int COLOR_W  = 12;
    localparam int N_LAYERS = 6;

    localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 12'hF0F;
    localparam logic [COLOR_W-1:0] BG_COLOR        = 12'h000;

    // Layer 0 is drawn on top of everything else.
    typedef enum logic [2:0] {
        LAYER_BOMBERMAN   = 3'd0,
        LAYER_ENEMY       = 3'd1,
        LAYER_BOMB        = 3'd2,
        LAYER_EXPLOSION   = 3'd3,
        LAYER_BREAKABLE   = 3'd4,
        LAYER_UNBREAKABLE = 3'd5
    } layer_id_e;

    // Index width for an n-entry vector, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational priority encoder: index of the lowest set bit of vec,
// with valid=0 and idx=0 when no bit is set.
module priority_encoder_n
    import video_pkg::*;
#(
    parameter int N = 6,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downwards so the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_layer_mixer.sv
// N-layer VGA pixel compositor: picks the highest-priority opaque layer,
// blanks outside the active area, delays syncs and latches per-frame collisions.
module pixel_layer_mixer
    import video_pkg::*;
#(
    parameter int                 N_LAYERS        = video_pkg::N_LAYERS,
    parameter int                 COLOR_W         = video_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR        = COLOR_W'(video_pkg::BG_COLOR),
    parameter bit                 TRANSPARENT_EN  = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = COLOR_W'(video_pkg::TRANSPARENT_KEY),
    parameter bit                 SYNC_ACTIVE_LOW = 1'b1,
    localparam int                IDX_W           = idx_width(N_LAYERS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_LAYERS-1:0]           layer_en,
    input  logic [N_LAYERS*COLOR_W-1:0]   layer_rgb,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [IDX_W-1:0]              top_layer,
    output logic                          top_valid,
    output logic [N_LAYERS-1:0]           collision_live,
    output logic [N_LAYERS-1:0]           collision_frame,
    output logic                          frame_done
);

    localparam logic SYNC_ASSERT = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_IDLE   = ~SYNC_ASSERT;

    // A pixel only counts as a collision when two or more layers are opaque on it.
    function automatic logic multi_hit(input logic [N_LAYERS-1:0] v);
        int cnt = 0;
        for (int i = 0; i < N_LAYERS; i++) begin
            cnt += int'(v[i]);
        end
        return cnt >= 2;
    endfunction

    logic [N_LAYERS-1:0]         opaque_in;
    logic [N_LAYERS-1:0]         opaque_p1;
    logic [N_LAYERS*COLOR_W-1:0] rgb_p1;
    logic                        vld_p1;
    logic                        hsync_p1;
    logic                        vsync_p1;

    logic [IDX_W-1:0]            sel_idx;
    logic                        sel_any;
    logic [COLOR_W-1:0]          pixel_p1;
    logic                        show_p1;
    logic [N_LAYERS-1:0]         hits_p1;
    logic                        boundary_p1;

    always_comb begin
        opaque_in = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque_in[i] = layer_en[i]
                & ~(TRANSPARENT_EN & (layer_rgb[i*COLOR_W +: COLOR_W] == TRANSPARENT_KEY));
        end
    end

    // ---- stage 1: capture opacity, colours, active flag and syncs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opaque_p1 <= '0;
            rgb_p1    <= '0;
            vld_p1    <= 1'b0;
            hsync_p1  <= SYNC_IDLE;
            vsync_p1  <= SYNC_IDLE;
        end else begin
            opaque_p1 <= opaque_in;
            rgb_p1    <= layer_rgb;
            vld_p1    <= video_on;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
        end
    end

    priority_encoder_n #(
        .N (N_LAYERS)
    ) u_prio (
        .vec   (opaque_p1),
        .idx   (sel_idx),
        .valid (sel_any)
    );

    always_comb begin
        pixel_p1    = rgb_p1[int'(sel_idx)*COLOR_W +: COLOR_W];
        show_p1     = vld_p1 & sel_any;
        hits_p1     = (vld_p1 && multi_hit(opaque_p1)) ? opaque_p1 : '0;
        // Compared against the already-delayed vsync so a held level yields one boundary.
        boundary_p1 = (vsync_p1 == SYNC_ASSERT) && (vsync_out == SYNC_IDLE);
    end

    // ---- stage 2: composited pixel, delayed syncs, collision bookkeeping ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out         <= '0;
            top_layer       <= '0;
            top_valid       <= 1'b0;
            hsync_out       <= SYNC_IDLE;
            vsync_out       <= SYNC_IDLE;
            collision_live  <= '0;
            collision_frame <= '0;
            frame_done      <= 1'b0;
        end else begin
            if (show_p1) begin
                rgb_out <= pixel_p1;
            end else if (vld_p1) begin
                rgb_out <= BG_COLOR;
            end else begin
                rgb_out <= '0;
            end
            top_layer  <= show_p1 ? sel_idx : '0;
            top_valid  <= show_p1;
            hsync_out  <= hsync_p1;
            vsync_out  <= vsync_p1;
            frame_done <= boundary_p1;
            if (boundary_p1) begin
                collision_frame <= collision_live | hits_p1;
                collision_live  <= '0;
            end else begin
                collision_live  <= collision_live | hits_p1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_layer_mixer.sv
// Bench for pixel_layer_mixer: directed cases plus a random pixel/sync stream
// against a priority-scan reference model, on a 6x12 and a 3x24 build.
module tb_pixel_layer_mixer;
    import video_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        video_on, hsync_in, vsync_in;
    logic [5:0]  en_a;
    logic [71:0] rgb_a;
    logic [2:0]  en_b;
    logic [71:0] rgb_b;

    logic [11:0] rgb_out_a;
    logic [2:0]  top_layer_a;
    logic        top_valid_a, hs_a, vs_a, done_a;
    logic [5:0]  live_a, frame_a;

    logic [23:0] rgb_out_b;
    logic [1:0]  top_layer_b;
    logic        top_valid_b, hs_b, vs_b, done_b;
    logic [2:0]  live_b, frame_b;

    pixel_layer_mixer dut_a (
        .clk(clk), .reset_n(reset_n), .layer_en(en_a), .layer_rgb(rgb_a),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_out(rgb_out_a), .hsync_out(hs_a), .vsync_out(vs_a),
        .top_layer(top_layer_a), .top_valid(top_valid_a),
        .collision_live(live_a), .collision_frame(frame_a), .frame_done(done_a)
    );

    pixel_layer_mixer #(
        .N_LAYERS(3), .COLOR_W(24), .BG_COLOR(24'h102030), .TRANSPARENT_KEY(24'hFF00FF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .layer_en(en_b), .layer_rgb(rgb_b),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_out(rgb_out_b), .hsync_out(hs_b), .vsync_out(vs_b),
        .top_layer(top_layer_b), .top_valid(top_valid_b),
        .collision_live(live_b), .collision_frame(frame_b), .frame_done(done_b)
    );

    typedef struct packed {
        logic         vid;
        logic         hs;
        logic         vs;
        logic [5:0]   en;
        logic [143:0] c;   // six 24-bit colours; the 12-bit build uses the low 12 bits
    } pix_t;

    pix_t       q[$];
    int         total  = 0;
    int         passed = 0;
    logic [5:0] m_live_a, m_frame_a;
    logic [2:0] m_live_b, m_frame_b;
    logic       m_prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: first enabled, non-keyed layer scanning from layer 0 wins.
    function automatic void model(input pix_t p, input int n, input logic [23:0] mask,
                                  input logic [23:0] key, input logic [23:0] bg,
                                  output logic [23:0] rgb, output int idx,
                                  output logic vld, output logic [5:0] opq);
        bit found = 0;
        opq = '0;
        idx = 0;
        vld = 1'b0;
        rgb = p.vid ? bg : 24'h0;
        for (int i = 0; i < n; i++)
            if (p.en[i] && ((p.c[i*24 +: 24] & mask) != key)) opq[i] = 1'b1;
        for (int i = 0; i < n; i++)
            if (opq[i] && !found) begin found = 1; idx = i; end
        if (p.vid && found) begin
            vld = 1'b1;
            rgb = p.c[idx*24 +: 24] & mask;
        end else begin
            idx = 0;
        end
    endfunction

    function automatic pix_t idle();
        pix_t p = '0;
        p.hs = 1'b1;
        p.vs = 1'b1;
        return p;
    endfunction

    function automatic pix_t rnd(input int cyc);
        pix_t p = '0;
        p.vid = ($urandom_range(0, 7) != 0);
        p.hs  = (cyc % 10) != 0;
        p.vs  = (cyc % 47) >= 3;
        p.en  = 6'($urandom & $urandom);
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0:       p.c[i*24 +: 24] = 24'h000F0F;
                1:       p.c[i*24 +: 24] = 24'hFF00FF;
                default: p.c[i*24 +: 24] = 24'($urandom);
            endcase
        end
        return p;
    endfunction

    task automatic drive(input pix_t p);
        en_a = p.en;
        en_b = p.en[2:0];
        for (int i = 0; i < 6; i++) rgb_a[i*12 +: 12] = p.c[i*24 +: 12];
        for (int i = 0; i < 3; i++) rgb_b[i*24 +: 24] = p.c[i*24 +: 24];
        video_on = p.vid;
        hsync_in = p.hs;
        vsync_in = p.vs;
    endtask

    task automatic tick();
        pix_t        e;
        logic [23:0] xr;
        int          xi;
        logic        xv, bnd;
        logic [5:0]  xo, hits;
        @(posedge clk);
        #1;
        e = q.pop_front();
        bnd = m_prev_vs && !e.vs;
        m_prev_vs = e.vs;

        model(e, 6, 24'h000FFF, 24'h000F0F, 24'h000000, xr, xi, xv, xo);
        check("a_rgb", 32'(rgb_out_a), 32'(xr));
        check("a_top_layer", 32'(top_layer_a), 32'(xi));
        check("a_top_valid", 32'(top_valid_a), 32'(xv));
        check("a_hsync", 32'(hs_a), 32'(e.hs));
        check("a_vsync", 32'(vs_a), 32'(e.vs));
        hits = (e.vid && $countones(xo) >= 2) ? xo : 6'h0;
        if (bnd) begin m_frame_a = m_live_a | hits; m_live_a = '0; end
        else m_live_a = m_live_a | hits;
        check("a_live", 32'(live_a), 32'(m_live_a));
        check("a_frame", 32'(frame_a), 32'(m_frame_a));
        check("a_done", 32'(done_a), 32'(bnd));

        model(e, 3, 24'hFFFFFF, 24'hFF00FF, 24'h102030, xr, xi, xv, xo);
        check("b_rgb", 32'(rgb_out_b), 32'(xr));
        check("b_top_layer", 32'(top_layer_b), 32'(xi));
        check("b_top_valid", 32'(top_valid_b), 32'(xv));
        check("b_vsync", 32'(vs_b), 32'(e.vs));
        check("b_hsync", 32'(hs_b), 32'(e.hs));
        hits = (e.vid && $countones(xo) >= 2) ? xo : 6'h0;
        if (bnd) begin m_frame_b = m_live_b | hits[2:0]; m_live_b = '0; end
        else m_live_b = m_live_b | hits[2:0];
        check("b_live", 32'(live_b), 32'(m_live_b));
        check("b_frame", 32'(frame_b), 32'(m_frame_b));
        check("b_done", 32'(done_b), 32'(bnd));
    endtask

    task automatic run(input pix_t p);
        drive(p);
        q.push_back(p);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle());
        reset_n = 1'b0;
        #1;
        check("rst_a_rgb", 32'(rgb_out_a), 32'h0);
        check("rst_a_top_valid", 32'(top_valid_a), 32'h0);
        check("rst_a_top_layer", 32'(top_layer_a), 32'h0);
        check("rst_a_live", 32'(live_a), 32'h0);
        check("rst_a_frame", 32'(frame_a), 32'h0);
        check("rst_a_done", 32'(done_a), 32'h0);
        check("rst_a_hsync", 32'(hs_a), 32'h1);
        check("rst_a_vsync", 32'(vs_a), 32'h1);
        check("rst_b_rgb", 32'(rgb_out_b), 32'h0);
        check("rst_b_live", 32'(live_b), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        q.push_back(idle());
        m_live_a  = '0;
        m_frame_a = '0;
        m_live_b  = '0;
        m_frame_b = '0;
        m_prev_vs = 1'b1;
    endtask

    initial begin
        pix_t p;
        reset_n = 1'b1;
        drive(idle());
        do_reset();

        // Transparency: keyed layer 0 falls through to layer 1.
        p = idle(); p.vid = 1'b1; p.en = 6'b000011;
        p.c[0*24 +: 24] = 24'h000F0F; p.c[1*24 +: 24] = 24'h00000F;
        run(p); run(idle());
        check("t3_rgb", 32'(rgb_out_a), 32'h00F);
        check("t3_top_layer", 32'(top_layer_a), 32'h1);
        check("t3_live", 32'(live_a), 32'h0);

        // Blanking and background.
        p = rnd(1); p.vid = 1'b0; p.hs = 1'b1; p.vs = 1'b1; p.en = 6'h3F;
        run(p); run(idle());
        check("t4_blank_rgb", 32'(rgb_out_a), 32'h0);
        check("t4_blank_valid", 32'(top_valid_a), 32'h0);
        check("t4_blank_live", 32'(live_a), 32'h0);
        p = idle(); p.vid = 1'b1;
        run(p); run(idle());
        check("t4_bg_a_rgb", 32'(rgb_out_a), 32'h000);
        check("t4_bg_b_rgb", 32'(rgb_out_b), 32'h102030);
        check("t4_bg_valid", 32'(top_valid_a), 32'h0);

        // Priority with two overlapping layers.
        p = idle(); p.vid = 1'b1; p.en = 6'b100001;
        p.c[0*24 +: 24] = 24'h000F00; p.c[5*24 +: 24] = 24'h0000F0;
        run(p); run(idle());
        check("t2_rgb", 32'(rgb_out_a), 32'hF00);
        check("t2_top_layer", 32'(top_layer_a), 32'h0);
        check("t2_live", 32'(live_a), 32'h21);

        for (int i = 0; i < 400; i++) run(rnd(i));

        do_reset();

        // Frame boundary: hits on 0 and 4, then vsync asserted and held.
        p = idle(); p.vid = 1'b1; p.en = 6'b010001;
        p.c[0*24 +: 24] = 24'h000F00; p.c[4*24 +: 24] = 24'h0000F0;
        run(p);
        p = idle(); p.vs = 1'b0;
        run(p);
        check("t5_done_early", 32'(done_a), 32'h0);
        run(p);
        check("t5_done", 32'(done_a), 32'h1);
        check("t5_frame", 32'(frame_a), 32'h11);
        check("t5_live", 32'(live_a), 32'h0);
        run(p);
        check("t5_done_once", 32'(done_a), 32'h0);
        check("t5_frame_hold", 32'(frame_a), 32'h11);
        run(idle()); run(idle());

        for (int i = 0; i < 300; i++) run(rnd(i + 7));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
